// File: rtl/usb_tx_bitstuff_ser_pkg.sv
// Shared definitions for the USB transmit serializer / bit stuffer and the matching
// receive-side destuffer.
//   SYNC_PAT  : SYNC byte, shifted out LSB first (0000_0001 on the wire)
//   STUFF_RUN : run of consecutive 1s that forces a stuffed 0
//   EOP_LEN   : cycles spent in EOP (2 SE0 + 1 J) with the NRZI encoder disabled
//   tx_state_e: serializer FSM states
package usb_tx_bitstuff_ser_pkg;

  localparam logic [7:0]  SYNC_PAT  = 8'h80;
  localparam int unsigned STUFF_RUN = 6;
  localparam int unsigned EOP_LEN   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StData,
    StEop
  } tx_state_e;

endpackage

// File: rtl/usb_bit_stuffer.sv
// Ones-run counter with stuff request, shared by the transmit stuffer and the receive
// destuffer.
// Ports:
//   clk       : bit clock, one bit per cycle
//   rst       : asynchronous active-low reset
//   bit_valid : bit_in is a live line bit this cycle; when low the run is cleared
//   bit_in    : bit currently on the line (stuffed 0s included)
//   stuff_req : the run including bit_in has reached StuffRun, so the next bit is a
//               stuff bit (inserted on transmit, removed on receive)
module usb_bit_stuffer
  import usb_tx_bitstuff_ser_pkg::*;
#(
  parameter int unsigned StuffRun = STUFF_RUN
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic bit_in,
  output logic stuff_req
);

  localparam int unsigned     CntW   = $clog2(StuffRun + 1);
  localparam logic [CntW-1:0] RunMax = CntW'(StuffRun);

  logic [CntW-1:0] run_q, run_d;

  // Run length including the current bit; any 0 (or an idle line) clears it.
  // Saturates so a malformed receive stream cannot wrap back below the threshold.
  always_comb begin
    run_d = '0;
    if (bit_valid && bit_in) begin
      run_d = (run_q == RunMax) ? RunMax : run_q + CntW'(1);
    end
  end

  assign stuff_req = (run_d == RunMax);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/usb_tx_bitstuff_ser.sv
// USB transmit serializer and bit stuffer feeding the NRZI encoder.
// Takes packet bytes over valid/ready, prepends SYNC, shifts bytes out LSB first one
// bit per clock, inserts a 0 after every StuffRun consecutive 1s and closes the packet
// with an EOP window during which the encoder is disabled.
// Ports:
//   clk         : system clock, one bit time per cycle
//   rst         : asynchronous active-low reset
//   tx_valid    : tx_data holds a byte; held high and stable until tx_ready
//   tx_data     : packet byte
//   tx_ready    : byte accepted this cycle
//   data_out    : serial bit to the NRZI encoder (registered)
//   en_nrzi_out : NRZI encoder enable (registered)
//   eop         : high during the EOP window (registered)
//   busy        : high in any state other than idle (registered)
module usb_tx_bitstuff_ser
  import usb_tx_bitstuff_ser_pkg::*;
#(
  parameter logic [7:0]  SyncPat  = SYNC_PAT,
  parameter int unsigned StuffRun = STUFF_RUN,
  parameter int unsigned EopLen   = EOP_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       data_out,
  output logic       en_nrzi_out,
  output logic       eop,
  output logic       busy
);

  localparam int unsigned     EopW    = $clog2(EopLen + 1);
  localparam logic [EopW-1:0] EopLast = EopW'(EopLen - 1);

  tx_state_e       state_q;
  logic [7:0]      sreg_q;      // byte being shown on data_out
  logic [2:0]      bit_idx_q;   // index of the bit on data_out (next bit during a stuff cycle)
  logic            stuff_q;     // data_out currently carries a stuffed 0
  logic            end_pend_q;  // packet ended on a bit that still needs its stuff 0
  logic [EopW-1:0] eop_cnt_q;

  logic       stuff_req;
  logic       boundary;
  logic [2:0] idx_nxt;

  // The run counter watches the line itself, so SYNC and stuffed 0s are counted too.
  usb_bit_stuffer #(
    .StuffRun (StuffRun)
  ) u_bit_stuffer (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (en_nrzi_out),
    .bit_in    (data_out),
    .stuff_req (stuff_req)
  );

  // Bit 7 of the current byte is on the line and is a real bit, not a stuff 0.
  assign boundary = ((state_q == StSync) || (state_q == StData)) && !stuff_q &&
                    (bit_idx_q == 3'd7);
  // Only asserted when a byte is actually taken, so an ending packet shows no pulse.
  assign tx_ready = boundary && tx_valid;
  assign idx_nxt  = bit_idx_q + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      bit_idx_q   <= '0;
      stuff_q     <= 1'b0;
      end_pend_q  <= 1'b0;
      eop_cnt_q   <= '0;
      data_out    <= 1'b1;
      en_nrzi_out <= 1'b0;
      eop         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // The first byte is not consumed here; it is taken at the SYNC bit-7 cycle.
          if (tx_valid) begin
            state_q     <= StSync;
            sreg_q      <= SyncPat;
            bit_idx_q   <= '0;
            stuff_q     <= 1'b0;
            end_pend_q  <= 1'b0;
            data_out    <= SyncPat[0];
            en_nrzi_out <= 1'b1;
            busy        <= 1'b1;
          end
        end

        StSync, StData: begin
          if (stuff_q) begin
            // Stuff cycle: shift position was already advanced, just resume output.
            stuff_q <= 1'b0;
            if (end_pend_q) begin
              state_q     <= StEop;
              eop_cnt_q   <= '0;
              data_out    <= 1'b1;
              en_nrzi_out <= 1'b0;
              eop         <= 1'b1;
            end else begin
              data_out <= sreg_q[bit_idx_q];
            end
          end else begin
            // Advance the bit position or handle the byte boundary. This runs even when
            // a stuff bit follows, so the stuff cycle itself leaves position frozen.
            if (bit_idx_q == 3'd7) begin
              if (tx_valid) begin
                sreg_q    <= tx_data;
                bit_idx_q <= '0;
                state_q   <= StData;
              end else begin
                end_pend_q <= 1'b1;
              end
            end else begin
              bit_idx_q <= idx_nxt;
            end

            if (stuff_req) begin
              stuff_q  <= 1'b1;
              data_out <= 1'b0;
            end else if (bit_idx_q == 3'd7) begin
              if (tx_valid) begin
                data_out <= tx_data[0];
              end else begin
                state_q     <= StEop;
                eop_cnt_q   <= '0;
                data_out    <= 1'b1;
                en_nrzi_out <= 1'b0;
                eop         <= 1'b1;
              end
            end else begin
              data_out <= sreg_q[idx_nxt];
            end
          end
        end

        StEop: begin
          // Returning to idle guarantees at least one idle cycle before the next SYNC.
          if (eop_cnt_q == EopLast) begin
            state_q <= StIdle;
            eop     <= 1'b0;
            busy    <= 1'b0;
          end else begin
            eop_cnt_q <= eop_cnt_q + EopW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_bitstuff_ser.sv
module tb_usb_tx_bitstuff_ser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, data_out, en_nrzi_out, eop, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic cap_d [64];
  logic cap_e [64];
  logic cap_eop [64];
  logic cap_b [64];
  logic cap_r [64];

  usb_tx_bitstuff_ser dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .data_out    (data_out),
    .en_nrzi_out (en_nrzi_out),
    .eop         (eop),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one packet of n bytes (0..2) and records outputs for ncyc cycles; cycle 0 is
  // the first cycle after the edge that sees tx_valid. At cycle revalid tx_valid is
  // raised again and held.
  task automatic run_pkt(input logic [7:0] b0, input logic [7:0] b1, input int n,
                         input int ncyc, input int revalid);
    int   idx;
    logic acc;
    idx      = 0;
    acc      = 1'b0;
    tx_data  = b0;
    tx_valid = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 && n == 0) tx_valid = 1'b0;
      if (acc) begin
        idx++;
        if (idx < n) tx_data = b1;
        else tx_valid = 1'b0;
      end
      if (k == revalid) begin
        tx_valid = 1'b1;
        tx_data  = 8'h00;
      end
      @(negedge clk);
      cap_d[k]   = data_out;
      cap_e[k]   = en_nrzi_out;
      cap_eop[k] = eop;
      cap_b[k]   = busy;
      cap_r[k]   = tx_ready;
      acc        = tx_ready & tx_valid;
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({data_out, en_nrzi_out, eop, busy, tx_ready} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_hold: d/en/eop/busy/rdy=%b%b%b%b%b want 10000",
               data_out, en_nrzi_out, eop, busy, tx_ready);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({data_out, en_nrzi_out, eop, busy, tx_ready} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_idle: d/en/eop/busy/rdy=%b%b%b%b%b want 10000",
               data_out, en_nrzi_out, eop, busy, tx_ready);
    end
  endtask

  task automatic test_byte_00();
    bit exp_d [20] = '{0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0, 1,1,1,1};
    int es = 16;
    run_pkt(8'h00, 8'h00, 1, 20, -1);
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (cap_d[k] !== exp_d[k] || cap_e[k] !== (k < es) ||
          cap_eop[k] !== (k >= es && k < es + 3) || cap_b[k] !== (k < es + 3) ||
          cap_r[k] !== (k == 7)) begin
        n_fail++;
        $display("FAIL byte00 cyc %0d: d/en/eop/busy/rdy=%b%b%b%b%b want %b%b%b%b%b", k,
                 cap_d[k], cap_e[k], cap_eop[k], cap_b[k], cap_r[k], exp_d[k], k < es,
                 k >= es && k < es + 3, k < es + 3, k == 7);
      end
    end
  endtask

  task automatic test_byte_ff();
    bit exp_d [21] = '{0,0,0,0,0,0,0,1, 1,1,1,1,1,0,1,1,1, 1,1,1,1};
    int es = 17;
    int nbusy = 0;
    run_pkt(8'hFF, 8'h00, 1, 21, -1);
    for (int k = 0; k < 21; k++) begin
      nbusy += int'(cap_b[k]);
      n_checks++;
      if (cap_d[k] !== exp_d[k] || cap_e[k] !== (k < es) ||
          cap_eop[k] !== (k >= es && k < es + 3) || cap_r[k] !== (k == 7)) begin
        n_fail++;
        $display("FAIL byteff cyc %0d: d/en/eop/rdy=%b%b%b%b want %b%b%b%b", k,
                 cap_d[k], cap_e[k], cap_eop[k], cap_r[k], exp_d[k], k < es,
                 k >= es && k < es + 3, k == 7);
      end
    end
    n_checks++;
    if (nbusy != 20) begin
      n_fail++;
      $display("FAIL byteff_busy_cycles: got %0d want 20", nbusy);
    end
  endtask

  task automatic test_stuff_last();
    bit exp_d [21] = '{0,0,0,0,0,0,0,1, 0,0,1,1,1,1,1,1,0, 1,1,1,1};
    int es = 17;
    run_pkt(8'hFC, 8'h00, 1, 21, -1);
    for (int k = 0; k < 21; k++) begin
      n_checks++;
      if (cap_d[k] !== exp_d[k] || cap_e[k] !== (k < es) ||
          cap_eop[k] !== (k >= es && k < es + 3) || cap_b[k] !== (k < es + 3) ||
          cap_r[k] !== (k == 7)) begin
        n_fail++;
        $display("FAIL stufflast cyc %0d: d/en/eop/busy/rdy=%b%b%b%b%b want %b%b%b%b%b", k,
                 cap_d[k], cap_e[k], cap_eop[k], cap_b[k], cap_r[k], exp_d[k], k < es,
                 k >= es && k < es + 3, k < es + 3, k == 7);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit exp_d [28] = '{0,0,0,0,0,0,0,1, 1,0,1,0,0,1,0,1, 0,1,0,1,1,0,1,0, 1,1,1,1};
    int es = 24;
    run_pkt(8'hA5, 8'h5A, 2, 28, -1);
    for (int k = 0; k < 28; k++) begin
      n_checks++;
      if (cap_d[k] !== exp_d[k] || cap_e[k] !== (k < es) ||
          cap_eop[k] !== (k >= es && k < es + 3) || cap_b[k] !== (k < es + 3) ||
          cap_r[k] !== (k == 7 || k == 15)) begin
        n_fail++;
        $display("FAIL b2b cyc %0d: d/en/eop/busy/rdy=%b%b%b%b%b want %b%b%b%b%b", k,
                 cap_d[k], cap_e[k], cap_eop[k], cap_b[k], cap_r[k], exp_d[k], k < es,
                 k >= es && k < es + 3, k < es + 3, k == 7 || k == 15);
      end
    end
  endtask

  task automatic test_zero_len();
    bit exp_d [12] = '{0,0,0,0,0,0,0,1, 1,1,1,1};
    int es = 8;
    run_pkt(8'h00, 8'h00, 0, 12, -1);
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if (cap_d[k] !== exp_d[k] || cap_e[k] !== (k < es) ||
          cap_eop[k] !== (k >= es && k < es + 3) || cap_b[k] !== (k < es + 3) ||
          cap_r[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL zerolen cyc %0d: d/en/eop/busy/rdy=%b%b%b%b%b want %b%b%b%b0", k,
                 cap_d[k], cap_e[k], cap_eop[k], cap_b[k], cap_r[k], exp_d[k], k < es,
                 k >= es && k < es + 3, k < es + 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit exp_d [21] = '{0,0,0,0,0,0,0,1, 1,1,1,1,1,0,1,1,1, 1,1,1,1};
    int es = 17;
    run_pkt(8'h00, 8'h00, 1, 12, -1);  // cycle 11 shows data bit 3
    n_checks++;
    if ({data_out, en_nrzi_out, busy} !== 3'b011) begin
      n_fail++;
      $display("FAIL mid_pre_reset: d/en/busy=%b%b%b want 011", data_out, en_nrzi_out, busy);
    end
    tx_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({data_out, en_nrzi_out, eop, busy, tx_ready} !== 5'b10000) begin
      n_fail++;
      $display("FAIL mid_async_reset: d/en/eop/busy/rdy=%b%b%b%b%b want 10000",
               data_out, en_nrzi_out, eop, busy, tx_ready);
    end
    tx_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({data_out, en_nrzi_out, eop, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL mid_reset_hold: d/en/eop/busy=%b%b%b%b want 1000",
               data_out, en_nrzi_out, eop, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    run_pkt(8'hFF, 8'h00, 1, 21, -1);
    for (int k = 0; k < 21; k++) begin
      n_checks++;
      if (cap_d[k] !== exp_d[k] || cap_e[k] !== (k < es) ||
          cap_eop[k] !== (k >= es && k < es + 3) || cap_b[k] !== (k < es + 3)) begin
        n_fail++;
        $display("FAIL after_reset cyc %0d: d/en/eop/busy=%b%b%b%b want %b%b%b%b", k,
                 cap_d[k], cap_e[k], cap_eop[k], cap_b[k], exp_d[k], k < es,
                 k >= es && k < es + 3, k < es + 3);
      end
    end
  endtask

  task automatic test_idle_gap();
    bit exp_d [21] = '{0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0, 1,1,1,1, 0};
    bit we, weop, wb;
    run_pkt(8'h00, 8'h00, 1, 21, 16);  // tx_valid back high from the first EOP cycle
    for (int k = 0; k < 21; k++) begin
      we   = (k < 16) || (k == 20);
      weop = (k >= 16) && (k < 19);
      wb   = (k < 19) || (k == 20);
      n_checks++;
      if (cap_d[k] !== exp_d[k] || cap_e[k] !== we || cap_eop[k] !== weop ||
          cap_b[k] !== wb || cap_r[k] !== (k == 7)) begin
        n_fail++;
        $display("FAIL idlegap cyc %0d: d/en/eop/busy/rdy=%b%b%b%b%b want %b%b%b%b%b", k,
                 cap_d[k], cap_e[k], cap_eop[k], cap_b[k], cap_r[k], exp_d[k], we, weop, wb,
                 k == 7);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_byte_00();
    test_byte_ff();
    test_stuff_last();
    test_back_to_back();
    test_zero_len();
    test_reset_mid();
    test_idle_gap();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
